// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy reporting, almost-full/empty thresholds,
// synchronous flush, sticky overflow/underflow flags and an optional first-word-fall-through read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic              almost_full_o,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              almost_empty_o,
    output logic [CW-1:0]     count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              rd_acc;
    logic              wr_acc;

    // Handshake: wr_en_i is a request that is taken when there is room (or a read frees
    // the slot on the same edge); rd_en_i pops the head only while the FIFO is non-empty.
    // Requests that are not taken are dropped and recorded in the sticky error flags.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_acc);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + CW'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - CW'(1);
            end
            if (wr_en_i && !wr_acc) overflow_q  <= 1'b1;
            if (rd_en_i && !rd_acc) underflow_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset; a flush suppresses the write on its edge.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr_i) mem[wr_ptr] <= data_i;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_o = mem[rd_ptr];
    end else begin : g_reg
        logic [DATA_W-1:0] data_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (clr_i) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= mem[rd_ptr];
            end
        end
        assign data_o = data_q;
    end

    assign count_o        = count_q;
    assign full_o         = (count_q == CW'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CW'(AF_THRESH));
    assign almost_empty_o = (count_q <= CW'(AE_THRESH));
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a default registered-read instance and a DEPTH=5 FWFT instance,
// both checked every cycle against queue-based models, plus directed literal expectations.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance a: defaults (DEPTH 16, AF 14, AE 2, registered read)
    logic       a_clr = 0, a_wr = 0, a_rd = 0;
    logic [7:0] a_din = 0, a_dout;
    logic       a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [4:0] a_count;

    // instance b: DEPTH 5, AF 4, AE 1, first-word-fall-through
    logic       b_clr = 0, b_wr = 0, b_rd = 0;
    logic [7:0] b_din = 0, b_dout;
    logic       b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    sync_fifo_param dut_a (
        .clk(clk), .rst_n(rst_n), .clr_i(a_clr), .wr_en_i(a_wr), .data_i(a_din),
        .full_o(a_full), .almost_full_o(a_af), .rd_en_i(a_rd), .data_o(a_dout),
        .empty_o(a_empty), .almost_empty_o(a_ae), .count_o(a_count),
        .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_i(b_clr), .wr_en_i(b_wr), .data_i(b_din),
        .full_o(b_full), .almost_full_o(b_af), .rd_en_i(b_rd), .data_o(b_dout),
        .empty_o(b_empty), .almost_empty_o(b_ae), .count_o(b_count),
        .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    int n_checks = 0;
    int n_fail = 0;

    // behavioural model: contents as queues, sticky flags, registered read word of instance a
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_ovf[2];
    bit         m_unf[2];
    logic [7:0] m_dout0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ovf[0] = 0; m_ovf[1] = 0;
        m_unf[0] = 0; m_unf[1] = 0;
        m_dout0 = 8'h00;
    endtask

    task automatic model_step(input int sel, input logic clr, input logic wr,
                              input logic rd, input logic [7:0] d);
        logic [7:0] q[$];
        logic [7:0] v;
        int depth;
        bit ra, wa;
        depth = (sel == 0) ? 16 : 5;
        if (sel == 0) q = q0; else q = q1;
        if (clr) begin
            q.delete();
            m_ovf[sel] = 0;
            m_unf[sel] = 0;
            if (sel == 0) m_dout0 = 8'h00;
        end else begin
            ra = rd && (q.size() != 0);
            wa = wr && ((q.size() < depth) || ra);
            if (wr && !wa) m_ovf[sel] = 1;
            if (rd && !ra) m_unf[sel] = 1;
            if (ra) begin
                v = q.pop_front();
                if (sel == 0) m_dout0 = v;
            end
            if (wa) q.push_back(d);
        end
        if (sel == 0) q0 = q; else q1 = q;
    endtask

    // one clock of activity on one instance; the other sits idle
    task automatic step(input int sel, input logic clr, input logic wr,
                        input logic rd, input logic [7:0] d);
        @(negedge clk);
        if (sel == 0) begin
            a_clr = clr; a_wr = wr; a_rd = rd; a_din = d;
        end else begin
            b_clr = clr; b_wr = wr; b_rd = rd; b_din = d;
        end
        @(posedge clk);
        #1;
        if (rst_n) model_step(sel, clr, wr, rd, d);
        a_clr = 0; a_wr = 0; a_rd = 0;
        b_clr = 0; b_wr = 0; b_rd = 0;
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("a_count", 32'(a_count), 32'(q0.size()));
        check("a_full", 32'(a_full), 32'(q0.size() == 16));
        check("a_af", 32'(a_af), 32'(q0.size() >= 14));
        check("a_empty", 32'(a_empty), 32'(q0.size() == 0));
        check("a_ae", 32'(a_ae), 32'(q0.size() <= 2));
        check("a_ovf", 32'(a_ovf), 32'(m_ovf[0]));
        check("a_unf", 32'(a_unf), 32'(m_unf[0]));
        check("a_data", 32'(a_dout), 32'(m_dout0));
        check("b_count", 32'(b_count), 32'(q1.size()));
        check("b_full", 32'(b_full), 32'(q1.size() == 5));
        check("b_af", 32'(b_af), 32'(q1.size() >= 4));
        check("b_empty", 32'(b_empty), 32'(q1.size() == 0));
        check("b_ae", 32'(b_ae), 32'(q1.size() <= 1));
        check("b_ovf", 32'(b_ovf), 32'(m_ovf[1]));
        check("b_unf", 32'(b_unf), 32'(m_unf[1]));
        if (q1.size() != 0) check("b_data", 32'(b_dout), 32'(q1[0]));
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", 32'(a_count), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_full", 32'(a_full), 0);
        check("rst_ae", 32'(a_ae), 1);
        check("rst_af", 32'(a_af), 0);
        check("rst_data", 32'(a_dout), 0);
        check("rst_ovf", 32'(a_ovf), 0);
        check("rst_unf", 32'(a_unf), 0);
        rst_n = 1;

        // fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 8'(i + 1));
            check("fill_af", 32'(a_af), 32'(i + 1 >= 14));
        end
        check("fill_count", 32'(a_count), 16);
        check("fill_full", 32'(a_full), 1);
        step(0, 0, 1, 0, 8'h99);
        check("ovf_set", 32'(a_ovf), 1);
        check("ovf_count", 32'(a_count), 16);

        // drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 1, 8'h00);
            check("drain_data", 32'(a_dout), 32'(i + 1));
        end
        check("drain_empty", 32'(a_empty), 1);
        step(0, 0, 0, 1, 8'h00);
        check("unf_set", 32'(a_unf), 1);
        check("unf_hold", 32'(a_dout), 32'h10);

        // full with simultaneous read/write
        step(0, 1, 0, 0, 8'h00);
        check("clr_ovf", 32'(a_ovf), 0);
        check("clr_unf", 32'(a_unf), 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(8'h21 + i));
        step(0, 0, 1, 1, 8'hAA);
        check("rw_full_count", 32'(a_count), 16);
        check("rw_full_ovf", 32'(a_ovf), 0);
        check("rw_full_data", 32'(a_dout), 32'h21);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
        check("rw_full_last", 32'(a_dout), 32'hAA);

        // empty with simultaneous read/write
        step(0, 0, 1, 1, 8'h55);
        check("rw_empty_count", 32'(a_count), 1);
        check("rw_empty_unf", 32'(a_unf), 1);
        step(0, 0, 0, 1, 8'h00);
        check("rw_empty_data", 32'(a_dout), 32'h55);

        // FWFT, non-power-of-two depth with pointer wrap
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 8'(8'h11 + i));
            check("fwft_head", 32'(b_dout), 32'h11);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 8'h00);
        check("fwft_show", 32'(b_dout), 32'h14);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 8'(8'h16 + i));
        check("fwft_full", 32'(b_full), 1);
        for (int i = 0; i < 5; i++) begin
            check("fwft_order", 32'(b_dout), 32'(8'h14 + i));
            step(1, 0, 0, 1, 8'h00);
        end
        check("fwft_empty", 32'(b_empty), 1);

        // flush a half-full FIFO with overflow set, write in the same cycle is dropped
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 8'h00);
        check("half_ovf", 32'(a_ovf), 1);
        step(0, 1, 1, 0, 8'hEE);
        check("flush_count", 32'(a_count), 0);
        check("flush_empty", 32'(a_empty), 1);
        check("flush_ovf", 32'(a_ovf), 0);
        check("flush_data", 32'(a_dout), 0);

        // asynchronous reset mid-stream, observed before any clock edge
        for (int i = 0; i < 4; i++) step(0, 0, 1, i[0], 8'(8'h60 + i));
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check("arst_count", 32'(a_count), 0);
        check("arst_empty", 32'(a_empty), 1);
        check("arst_data", 32'(a_dout), 0);
        check("arst_ae", 32'(a_ae), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 1, 0, 8'h77);
        check("post_rst_count", 32'(a_count), 1);
        step(0, 0, 0, 1, 8'h00);
        check("post_rst_data", 32'(a_dout), 32'h77);

        // randomized traffic with write-heavy, read-heavy and balanced epochs
        for (int i = 0; i < 1500; i++) begin
            int sel, pw, pr;
            case ((i / 150) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            sel = $urandom_range(0, 1);
            step(sel, $urandom_range(0, 99) == 0, $urandom_range(0, 99) < pw,
                 $urandom_range(0, 99) < pr, 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
